// File: rtl/uart_pkg.sv
// uart_pkg: encodings and helpers shared by the UART transmitter, receiver
// and APB register block.
// Optional feature macro used by uart_tx: UART_TX_BREAK_EN.
package uart_pkg;

  // Transmit FSM states, one per field of the serial frame
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_e;

  // LCR word-length select encodings
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // LCR parity-select encodings
  localparam logic [1:0] PS_EVEN  = 2'b00;
  localparam logic [1:0] PS_ODD   = 2'b01;
  localparam logic [1:0] PS_MARK  = 2'b10;
  localparam logic [1:0] PS_SPACE = 2'b11;

  // Index of the last data bit for a word length: N-1 = 4 + wls
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    return 3'd4 + {1'b0, wls};
  endfunction

  // Keep only the bits that belong to the configured word length
  function automatic logic [7:0] word_mask(input logic [1:0] wls);
    logic [7:0] m;
    m = 8'hFF;
    case (wls)
      WLS_5:   m = 8'h1F;
      WLS_6:   m = 8'h3F;
      WLS_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Parity bit for the active data bits under the selected parity mode
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic [1:0] ps);
    logic p;
    p = ^(data & word_mask(wls));
    case (ps)
      PS_EVEN:  return p;
      PS_ODD:   return ~p;
      PS_MARK:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter. Counts 0..div_i while enabled and
// pulses bit_end_o on the last cycle of each period, then wraps to 0.
// Cleared on reset and whenever a new frame is accepted, so every frame
// starts its first bit period with a full count.
module uart_baud_cnt #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 bit_end_o
);

  logic [DIV_WIDTH-1:0] cnt_reg;

  assign bit_end_o = en_i && (cnt_reg == div_i);

  // Free-running period counter, wrapping on the final cycle of each bit
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_reg <= '0;
    end else if (en_i) begin
      if (bit_end_o) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART frame serializer fed from the TX FIFO by valid/ready.
// Frame: start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
// All frame configuration is captured at the handshake, so register
// writes during a frame only affect the next one.
// Optional feature macro: UART_TX_BREAK_EN adds break_i, which holds the
// line low while the transmitter is idle.
module uart_tx #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [1:0]           wls_i,
  input  logic                 stb_i,
  input  logic                 pen_i,
  input  logic [1:0]           ps_i,
  input  logic [7:0]           data_i,
  input  logic                 valid_i,
`ifdef UART_TX_BREAK_EN
  input  logic                 break_i,
`endif
  output logic                 ready_o,
  output logic                 tx_o
);

  import uart_pkg::*;

  uart_tx_state_e       state_reg;
  logic                 tx_reg;
  logic                 ready_reg;
  logic [7:0]           shift_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [2:0]           last_idx_reg;
  logic [2:0]           bit_idx_reg;
  logic                 stb_reg;
  logic                 pen_reg;
  logic                 par_reg;
  logic                 stop_idx_reg;

  logic accept;
  logic bit_end;
  logic break_req;

  assign accept  = valid_i && ready_reg;
  assign ready_o = ready_reg;
  assign tx_o    = tx_reg;

`ifdef UART_TX_BREAK_EN
  assign break_req = break_i;
`else
  assign break_req = 1'b0;
`endif

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (accept),
    .en_i      (state_reg != IDLE),
    .div_i     (div_reg),
    .bit_end_o (bit_end)
  );

  // Frame sequencer: captures config on accept, steps one field per bit period
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      tx_reg       <= 1'b1;
      ready_reg    <= 1'b1;
      shift_reg    <= '0;
      div_reg      <= '0;
      last_idx_reg <= '0;
      bit_idx_reg  <= '0;
      stb_reg      <= 1'b0;
      pen_reg      <= 1'b0;
      par_reg      <= 1'b0;
      stop_idx_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg    <= START;
            tx_reg       <= 1'b0;
            ready_reg    <= 1'b0;
            shift_reg    <= data_i;
            div_reg      <= div_i;
            last_idx_reg <= last_bit_idx(wls_i);
            bit_idx_reg  <= '0;
            stb_reg      <= stb_i;
            pen_reg      <= pen_i;
            par_reg      <= calc_parity(data_i, wls_i, ps_i);
            stop_idx_reg <= 1'b0;
          end else begin
            // Break holds the line at space and withholds ready
            tx_reg    <= ~break_req;
            ready_reg <= ~break_req;
          end
        end

        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            tx_reg      <= shift_reg[0];
            bit_idx_reg <= '0;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx_reg == last_idx_reg) begin
              if (pen_reg) begin
                state_reg <= PARITY;
                tx_reg    <= par_reg;
              end else begin
                state_reg    <= STOP;
                tx_reg       <= 1'b1;
                stop_idx_reg <= 1'b0;
              end
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              shift_reg   <= {1'b0, shift_reg[7:1]};
              tx_reg      <= shift_reg[1];
            end
          end
        end

        PARITY: begin
          if (bit_end) begin
            state_reg    <= STOP;
            tx_reg       <= 1'b1;
            stop_idx_reg <= 1'b0;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_idx_reg == stb_reg) begin
              state_reg <= IDLE;
              tx_reg    <= 1'b1;
              ready_reg <= 1'b1;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          tx_reg    <= 1'b1;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule
